// File: rtl/moore_seq_detector.sv
`default_nettype none
// ============================================================================
// Module  : moore_seq_detector
// Brief   : Moore serial pattern detector. It matches a runtime-loadable
//           pattern and falls back KMP-style after a mismatch.
//           Optional match counter: define MOORE_SEQ_MATCH_COUNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module moore_seq_detector #(
   parameter int                 PAT_LEN       = 4,
   parameter logic [PAT_LEN-1:0] RESET_PATTERN = 4'b1011,
   parameter int                 CNT_W         = 8,
   localparam int                SW            = $clog2(PAT_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_valid,
   input  logic               i_input,
   input  logic               i_load,
   input  logic [PAT_LEN-1:0] i_pattern,
   input  logic               i_overlap,
   output logic               o_output,
   output logic [SW-1:0]      o_current_state,
   output logic [SW-1:0]      o_next_state,
   output logic [CNT_W-1:0]   o_match_count
);

   localparam logic [SW-1:0] MATCH = SW'(PAT_LEN);

   generate
      if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
         $error("moore_seq_detector: PAT_LEN must be in 2..16");
      end
   endgenerate

   logic [PAT_LEN-1:0] pattern_q, pattern_d;
   logic [SW-1:0]      state_q, state_d;

   // The candidate string is the matched prefix followed by the new bit.
   // k is a valid fallback if the prefix of length k equals the tail of that
   // string. The pattern's first bit is held in bit PAT_LEN-1.
   function automatic logic [SW-1:0] f_next_state(
      input logic [PAT_LEN-1:0] pat,
      input logic [SW-1:0]      s,
      input logic               bit_in,
      input logic               overlap
   );
      int            base;
      int            idx;
      logic          ok;
      logic [SW-1:0] best;
      base = (int'(s) == PAT_LEN && !overlap) ? 0 : int'(s);
      best = '0;
      for (int k = 1; k <= PAT_LEN; k++) begin
         if (k <= base + 1) begin
            ok = (pat[PAT_LEN-k] == bit_in);
            for (int j = 0; j < PAT_LEN - 1; j++) begin
               if (j < k - 1) begin
                  idx = base + 1 - k + j;
                  if (pat[PAT_LEN-1-j] != pat[PAT_LEN-1-idx]) begin
                     ok = 1'b0;
                  end
               end
            end
            if (ok) begin
               best = SW'(k);
            end
         end
      end
      return best;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= '0;
         pattern_q <= RESET_PATTERN;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      if (i_load) begin
         state_d   = '0;
         pattern_d = i_pattern;
      end else if (i_valid) begin
         state_d = f_next_state(pattern_q, state_q, i_input, i_overlap);
      end
   end

   assign o_output        = (state_q == MATCH);
   assign o_current_state = state_q;
   assign o_next_state    = state_d;

`ifdef MOORE_SEQ_MATCH_COUNT_EN
   logic [CNT_W-1:0] count_q, count_d;

   // Staying in MATCH counts again, so the increment keys off state_d.
   always_comb begin
      count_d = count_q;
      if (i_load) begin
         count_d = '0;
      end else if (i_valid && state_d == MATCH && count_q != {CNT_W{1'b1}}) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_match_count = count_q;
`else
   assign o_match_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_moore_seq_detector.sv
`default_nettype none
// ============================================================================
// Module  : tb_moore_seq_detector
// Brief   : Self-checking bench for moore_seq_detector with a history-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_moore_seq_detector;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid, din, load, ov;
   logic [3:0] pat;

   logic       out_a, out_b;
   logic [2:0] cur_a, nxt_a, cur_b, nxt_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   int checks   = 0;
   int failures = 0;

   // Reference model: the last accepted bits plus the current pattern.
   bit         m_hist[$];
   logic [3:0] m_pat;
   int         m_state, m_cnt8, m_cnt2;

   moore_seq_detector #(.PAT_LEN(4), .RESET_PATTERN(4'b1011), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .i_valid(valid), .i_input(din), .i_load(load),
      .i_pattern(pat), .i_overlap(ov), .o_output(out_a), .o_current_state(cur_a),
      .o_next_state(nxt_a), .o_match_count(cnt_a));

   moore_seq_detector #(.PAT_LEN(4), .RESET_PATTERN(4'b1011), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .i_valid(valid), .i_input(din), .i_load(load),
      .i_pattern(pat), .i_overlap(ov), .o_output(out_b), .o_current_state(cur_b),
      .o_next_state(nxt_b), .o_match_count(cnt_b));

   always #5 clk = ~clk;

   function automatic int exp_cnt(input int c);
`ifdef MOORE_SEQ_MATCH_COUNT_EN
      return c;
`else
      return 0;
`endif
   endfunction

   // Longest pattern prefix that is also a suffix of the history.
   function automatic int longest(input bit h[$], input logic [3:0] p);
      int  best = 0;
      bit  ok;
      for (int k = 1; k <= 4; k++) begin
         if (k <= h.size()) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
               if (h[h.size() - k + j] != p[3 - j]) ok = 1'b0;
            if (ok) best = k;
         end
      end
      return best;
   endfunction

   function automatic int predict(input bit b, input bit o);
      bit h[$];
      h = m_hist;
      if (m_state == 4 && !o) h = {};
      h.push_back(b);
      return longest(h, m_pat);
   endfunction

   function automatic int model_next();
      if (load)  return 0;
      if (valid) return predict(din, ov);
      return m_state;
   endfunction

   task automatic model_reset();
      m_pat   = 4'b1011;
      m_hist  = {};
      m_state = 0;
      m_cnt8  = 0;
      m_cnt2  = 0;
   endtask

   task automatic drive(input bit v, input bit b, input bit l, input logic [3:0] p, input bit o);
      valid = v; din = b; load = l; pat = p; ov = o;
   endtask

   task automatic tick();
      int n;
      @(posedge clk);
      if (load) begin
         m_pat = pat; m_hist = {}; m_state = 0; m_cnt8 = 0; m_cnt2 = 0;
      end else if (valid) begin
         n = predict(din, ov);
         if (m_state == 4 && !ov) m_hist = {};
         m_hist.push_back(din);
         if (m_hist.size() > 4) void'(m_hist.pop_front());
         m_state = n;
         if (n == 4) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3)   m_cnt2++;
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      drive(0, 0, 0, 4'b0000, 1);
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bit seq[4] = '{1, 0, 1, 1};
      int exp_s[4] = '{1, 2, 3, 4};
      apply_reset();
      checks++;
      if (cur_a !== 3'd0 || out_a !== 1'b0 || cnt_a !== 8'd0) begin
         failures++;
         $display("FAIL reset: state=%0d out=%0d cnt=%0d expected 0/0/0", cur_a, out_a, cnt_a);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, seq[i], 0, 4'b0000, 1);
         tick();
         checks++;
         if (cur_a !== 3'(exp_s[i]) || out_a !== (i == 3)) begin
            failures++;
            $display("FAIL reset_stream[%0d]: state=%0d out=%0d expected %0d/%0d", i, cur_a, out_a, exp_s[i], (i == 3));
         end
      end
   endtask

   task automatic run_stream(input string name, input bit o, input int exp_c);
      bit seq[7] = '{1, 0, 1, 1, 0, 1, 1};
      int exp_ov[7] = '{1, 2, 3, 4, 2, 3, 4};
      int exp_no[7] = '{1, 2, 3, 4, 0, 1, 1};
      int e, highs = 0;
      apply_reset();
      for (int i = 0; i < 7; i++) begin
         drive(1, seq[i], 0, 4'b0000, o);
         tick();
         e = o ? exp_ov[i] : exp_no[i];
         if (out_a === 1'b1) highs++;
         checks++;
         if (cur_a !== 3'(e)) begin
            failures++;
            $display("FAIL %s[%0d]: state=%0d expected %0d", name, i, cur_a, e);
         end
      end
      checks++;
      if (highs != exp_c || cnt_a !== 8'(exp_cnt(exp_c))) begin
         failures++;
         $display("FAIL %s_count: highs=%0d cnt=%0d expected %0d/%0d", name, highs, cnt_a, exp_c, exp_cnt(exp_c));
      end
   endtask

   task automatic test_overlap();
      run_stream("overlap", 1'b1, 2);
   endtask

   task automatic test_non_overlap();
      run_stream("nonoverlap", 1'b0, 1);
   endtask

   task automatic test_stall();
      apply_reset();
      drive(1, 1, 0, 4'b0000, 1); tick();
      drive(1, 0, 0, 4'b0000, 1); tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, i[0], 0, 4'b0000, 1);
         #1;
         checks++;
         if (nxt_a !== 3'd2) begin
            failures++;
            $display("FAIL stall_next[%0d]: next=%0d expected 2", i, nxt_a);
         end
         tick();
         checks++;
         if (cur_a !== 3'd2) begin
            failures++;
            $display("FAIL stall_state[%0d]: state=%0d expected 2", i, cur_a);
         end
      end
      drive(1, 1, 0, 4'b0000, 1); tick();
      drive(1, 1, 0, 4'b0000, 1); tick();
      checks++;
      if (cur_a !== 3'd4 || out_a !== 1'b1) begin
         failures++;
         $display("FAIL stall_resume: state=%0d out=%0d expected 4/1", cur_a, out_a);
      end
   endtask

   task automatic test_load_and_saturation();
      int exp_s[8] = '{1, 2, 3, 4, 4, 4, 4, 4};
      apply_reset();
      drive(1, 1, 0, 4'b0000, 1); tick();
      drive(1, 0, 0, 4'b0000, 1); tick();
      drive(1, 1, 0, 4'b0000, 1); tick();
      drive(1, 1, 1, 4'b1111, 1);
      #1;
      checks++;
      if (cur_a !== 3'd3 || nxt_a !== 3'd0) begin
         failures++;
         $display("FAIL load_next: state=%0d next=%0d expected 3/0", cur_a, nxt_a);
      end
      tick();
      checks++;
      if (cur_a !== 3'd0 || cnt_a !== 8'd0) begin
         failures++;
         $display("FAIL load_state: state=%0d cnt=%0d expected 0/0", cur_a, cnt_a);
      end
      for (int i = 0; i < 8; i++) begin
         drive(1, 1, 0, 4'b0000, 1);
         tick();
         checks++;
         if (cur_a !== 3'(exp_s[i])) begin
            failures++;
            $display("FAIL load_stream[%0d]: state=%0d expected %0d", i, cur_a, exp_s[i]);
         end
         if (i == 5) begin
            checks++;
            if (cnt_a !== 8'(exp_cnt(3))) begin
               failures++;
               $display("FAIL load_count: cnt=%0d expected %0d", cnt_a, exp_cnt(3));
            end
         end
      end
      checks++;
      if (cnt_a !== 8'(exp_cnt(5)) || cnt_b !== 2'(exp_cnt(3))) begin
         failures++;
         $display("FAIL saturation: cnt8=%0d cnt2=%0d expected %0d/%0d", cnt_a, cnt_b, exp_cnt(5), exp_cnt(3));
      end
   endtask

   task automatic test_async_reset();
      bit seq[4] = '{1, 0, 1, 1};
      apply_reset();
      drive(1, 0, 1, 4'b1111, 1); tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, 1, 0, 4'b0000, 1); tick();
      end
      checks++;
      if (cur_a !== 3'd4) begin
         failures++;
         $display("FAIL async_setup: state=%0d expected 4", cur_a);
      end
      drive(0, 0, 0, 4'b0000, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (cur_a !== 3'd0 || out_a !== 1'b0 || cnt_a !== 8'd0) begin
         failures++;
         $display("FAIL async_reset: state=%0d out=%0d cnt=%0d expected 0/0/0", cur_a, out_a, cnt_a);
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1, seq[i], 0, 4'b0000, 1); tick();
      end
      checks++;
      if (cur_a !== 3'd4 || out_a !== 1'b1) begin
         failures++;
         $display("FAIL async_pattern_restore: state=%0d out=%0d expected 4/1", cur_a, out_a);
      end
   endtask

   task automatic test_random();
      int n;
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 39) == 0,
               4'($urandom), 1'($urandom));
         #1;
         n = model_next();
         checks++;
         if (nxt_a !== 3'(n) || nxt_b !== 3'(n)) begin
            failures++;
            $display("FAIL rand_next[%0d]: next=%0d/%0d expected %0d", i, nxt_a, nxt_b, n);
         end
         tick();
         checks++;
         if (cur_a !== 3'(m_state) || out_a !== (m_state == 4) || cur_b !== 3'(m_state) ||
             cnt_a !== 8'(exp_cnt(m_cnt8)) || cnt_b !== 2'(exp_cnt(m_cnt2))) begin
            failures++;
            $display("FAIL rand_state[%0d]: state=%0d out=%0d cnt=%0d/%0d expected %0d/%0d/%0d/%0d",
                     i, cur_a, out_a, cnt_a, cnt_b, m_state, (m_state == 4), exp_cnt(m_cnt8), exp_cnt(m_cnt2));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 4'b0000, 1);
      model_reset();
      test_reset();
      test_overlap();
      test_non_overlap();
      test_stall();
      test_load_and_saturation();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
